// File: rtl/afifo_rd_drain.sv
// afifo_rd_drain: read-side burst consumer for the FIFO.
// Pops a programmed number of words through the FIFO read port and presents
// them on a valid/ready stream. A 2-entry output buffer absorbs the FIFO's
// 1-cycle read latency so a burst can sustain one word per cycle.
module afifo_rd_drain #(
  parameter int D_WIDTH = 8,
  parameter int ADDRS   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               burst_start,
  input  logic [ADDRS-1:0]   burst_len,
  input  logic               enable,
  input  logic               fifo_empty,
  input  logic [D_WIDTH-1:0] fifo_rdata,
  output logic               fifo_pop,
  output logic               m_valid,
  output logic [D_WIDTH-1:0] m_data,
  input  logic               m_ready,
  output logic               busy,
  output logic               done,
  output logic [ADDRS-1:0]   words_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDRS-1:0]   words_left_q, words_left_d;
  logic [ADDRS-1:0]   pop_left_q, pop_left_d;
  logic               inflight_q;
  logic [1:0]         occ_q, occ_d;
  logic [D_WIDTH-1:0] buf0_q, buf0_d;
  logic [D_WIDTH-1:0] buf1_q, buf1_d;

  logic               xfer;
  logic [2:0]         need_cnt;

  // Next-state, pop decision and buffer bookkeeping from registered state.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    pop_left_d   = pop_left_q;
    occ_d        = occ_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;

    xfer     = (occ_q != 2'd0) && m_ready;
    // Slots that will be committed after this edge; a pop is only allowed
    // when its word is guaranteed a free slot on capture.
    need_cnt = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};
    fifo_pop = (state_q == DRAIN) && enable && !fifo_empty &&
               (pop_left_q != '0) && (need_cnt < 3'd2);

    // Buffer: capture the word popped last cycle and/or retire the head.
    unique case ({inflight_q, xfer})
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_rdata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rdata;
        end
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = fifo_rdata;
        end else begin
          buf1_d = fifo_rdata;
        end
        occ_d = occ_q + 2'd1;
      end
      default: begin
      end
    endcase

    if (fifo_pop) begin
      pop_left_d = pop_left_q - 1'b1;
    end
    if (xfer) begin
      words_left_d = words_left_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (burst_start) begin
          words_left_d = burst_len;
          pop_left_d   = burst_len;
          state_d      = (burst_len != '0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        // The transfer of the final word ends the burst; every pop has
        // been issued and captured by then because counts are exact.
        if (xfer && (words_left_q == {{(ADDRS-1){1'b0}}, 1'b1})) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and output buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
      occ_q        <= 2'd0;
      buf0_q       <= '0;
      buf1_q       <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      pop_left_q   <= pop_left_d;
      inflight_q   <= fifo_pop;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
    end
  end

  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = buf0_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign words_left = words_left_q;

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Directed bench for afifo_rd_drain with a FIFO model and a word scoreboard.
module tb_afifo_rd_drain;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          burst_start;
  logic [AW-1:0] burst_len;
  logic          enable;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_pop;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic [AW-1:0] words_left;

  afifo_rd_drain #(.D_WIDTH(DW), .ADDRS(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_pop   (fifo_pop),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done),
    .words_left (words_left)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // FIFO model: storage written by the stimulus, read pointer moved on pops.
  logic [DW-1:0] mem [0:255];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_pop) begin
      fifo_rdata <= mem[rd_ptr[7:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [DW-1:0] d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  // Stream monitors sampled on the falling edge.
  int            outstanding = 0;
  bit            prev_stall  = 1'b0;
  logic [DW-1:0] prev_data   = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("sb_extra_word", 32'(m_data), 32'hFFFF_FFFF);
        else chk("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (fifo_pop) chk("underflow", 32'(fifo_empty), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      outstanding = outstanding + int'(fifo_pop) - int'(m_valid && m_ready);
      if (outstanding > 2) chk("occ_inflight_le2", 32'(outstanding), 32'd2);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic run_until_done(input int maxc, input bit toggle, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      tick();
      if (toggle) m_ready = ~m_ready;
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_exact_pops"}, 32'(rd_ptr), 32'(wr_ptr));
    m_ready = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    burst_start = 1'b0;
    burst_len   = '0;
    enable      = 1'b1;
    m_ready     = 1'b1;
    for (int i = 0; i < 5; i++) fifo_write(8'h10 + 8'(i));

    // Reset state.
    #2;
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wl", 32'(words_left), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Burst of 5 with m_ready held high: exact cycle timeline.
    burst_start = 1'b1;
    burst_len   = 4'd5;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
    tick();
    burst_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("t1_pop_T%0d", c), 32'(fifo_pop), 32'((c >= 1) && (c <= 5)));
      chk($sformatf("t1_valid_T%0d", c), 32'(m_valid), 32'((c >= 3) && (c <= 7)));
      chk($sformatf("t1_done_T%0d", c), 32'(done), 32'(c == 8));
      chk($sformatf("t1_busy_T%0d", c), 32'(busy), 32'(c <= 8));
      tick();
    end
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // Same burst with m_ready toggling.
    for (int i = 0; i < 5; i++) fifo_write(8'h30 + 8'(i));
    burst_start = 1'b1;
    burst_len   = 4'd5;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h30 + 8'(i));
    tick();
    burst_start = 1'b0;
    m_ready     = 1'b0;
    run_until_done(40, 1'b1, "t2");
    tick();

    // FIFO runs dry mid-burst, then refills.
    fifo_write(8'h20);
    fifo_write(8'h21);
    burst_start = 1'b1;
    burst_len   = 4'd4;
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    tick();
    burst_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    chk("t3_stall_busy", 32'(busy), 32'd1);
    chk("t3_stall_wl", 32'(words_left), 32'd2);
    chk("t3_stall_valid", 32'(m_valid), 32'd0);
    tick();
    fifo_write(8'hA0);
    tick();
    fifo_write(8'hA1);
    run_until_done(20, 1'b0, "t3");
    tick();

    // enable dropped for 3 cycles mid-burst.
    for (int i = 0; i < 8; i++) fifo_write(8'h40 + 8'(i));
    burst_start = 1'b1;
    burst_len   = 4'd8;
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h40 + 8'(i));
    tick();
    burst_start = 1'b0;
    tick();
    tick();
    tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t4_no_pop_%0d", i), 32'(fifo_pop), 32'd0);
      chk($sformatf("t4_busy_%0d", i), 32'(busy), 32'd1);
      tick();
    end
    enable = 1'b1;
    run_until_done(30, 1'b0, "t4");
    tick();

    // Zero-length burst.
    burst_start = 1'b1;
    burst_len   = 4'd0;
    tick();
    burst_start = 1'b0;
    @(negedge clk);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_pop", 32'(fifo_pop), 32'd0);
    chk("t5_valid", 32'(m_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_done_once", 32'(done), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);
    tick();

    // burst_start while busy is ignored.
    for (int i = 0; i < 3; i++) fifo_write(8'h50 + 8'(i));
    for (int i = 0; i < 4; i++) fifo_write(8'h60 + 8'(i));
    burst_start = 1'b1;
    burst_len   = 4'd3;
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h50 + 8'(i));
    tick();
    burst_len = 4'd7;
    tick();
    burst_start = 1'b0;
    burst_len   = 4'd0;
    @(negedge clk);
    chk("t5_ign_wl", 32'(words_left), 32'd3);
    chk("t5_ign_busy", 32'(busy), 32'd1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
        tick();
      end
      chk("t5_ign_done", 32'(seen), 32'd1);
      chk("t5_ign_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("t5_ign_pops", 32'(rd_ptr), 32'(wr_ptr - 4));
    end
    tick();

    // Reset mid-burst with the buffer full.
    m_ready     = 1'b0;
    burst_start = 1'b1;
    burst_len   = 4'd4;
    tick();
    burst_start = 1'b0;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("t6_pre_valid", 32'(m_valid), 32'd1);
    chk("t6_pre_pop", 32'(fifo_pop), 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_pop", 32'(fifo_pop), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_wl", 32'(words_left), 32'd0);
    chk("t6_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    tick();
    @(negedge clk);
    chk("t6_rst_no_done", 32'(done), 32'd0);
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_post_done", 32'(done), 32'd0);
    tick();

    // New burst continues from the FIFO head (0x60, 0x61 were discarded).
    burst_start = 1'b1;
    burst_len   = 4'd2;
    exp_q.push_back(8'h62);
    exp_q.push_back(8'h63);
    tick();
    burst_start = 1'b0;
    run_until_done(20, 1'b0, "t6_after");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
